ladder_array_renderer: RTL
==========================

// Module: ladder_array_renderer
// PURPOSE
//  Parametrised ladder overlay: draws NUM_LADDERS vertical ladders, each TILE_W wide, from one
//  shared TILE_W x TILE_H sprite ROM tiled vertically. Sits in the vga_if chain after the
//  background/platform stage. On start_game each ladder grows upward row by row from its
//  bottom edge, then holds. Texels equal to KEY_RGB are transparent.
// PARAMETERS
//  NUM_LADDERS  4       number of ladder columns (1..8)
//  TILE_W       32      sprite width in pixels, power of 2
//  TILE_H       32      sprite height in pixels, power of 2
//  STEP_FRAMES  2       frames per revealed row during growth (>=1)
//  KEY_RGB      12'hF0F transparent texel colour
//  BLANK_RGB    12'h888 rgb driven during hblnk/vblnk
// PORTS
//  clk          in   1                        pixel clock
//  rst_n        in   1                        asynchronous reset, active-low
//  start_game   in   1                        level: 1 = ladders active
//  x_left       in   NUM_LADDERS*11           packed left column of each ladder
//  y_top        in   NUM_LADDERS*11           packed top row (inclusive)
//  y_bot        in   NUM_LADDERS*11           packed bottom row (inclusive), y_bot >= y_top
//  rgb_pixel    in   12                       ROM data, valid 1 clk after pixel_addr
//  pixel_addr   out  $clog2(TILE_W*TILE_H)    ROM address {row,col}
//  grow_done    out  1                        1 while FSM in HOLD
//  in           vga_if.in                     timing + background rgb
//  out          vga_if.out                    timing + composited rgb
// BEHAVIOUR
//  - Reset (async assert, sync deassert via rst_n): all out.* = 0, pixel_addr = 0,
//    grow_done = 0, reveal = 0, frame_cnt = 0, FSM = IDLE.
//  - Latency: 3 clk for every out.* field. C1: hit detect + pixel_addr registered from in.*;
//    C2: ROM data returns, hit/index/background piped; C3: out.* registered.
//  - Hit for ladder i: x_left[i] <= hcount < x_left[i]+TILE_W and
//    max(y_top[i], y_bot[i]-reveal+1) <= vcount <= y_bot[i] and FSM != IDLE; reveal=0 => no hit.
//  - Address: col = (hcount - x_left[i])[log2 TILE_W-1:0], row = (vcount - y_top[i]) mod
//    TILE_H (tile phase anchored at y_top). No hit: pixel_addr holds previous value.
//  - Overlap: lowest index ladder wins.
//  - Compose (C3): blank (hblnk|vblnk at C2) -> BLANK_RGB; hit & rgb_pixel != KEY_RGB -> rgb_pixel;
//    else background rgb.
//  - Frame tick: one-cycle pulse on rising edge of in.vsync.
//  - FSM: IDLE --start_game=1--> GROW (reveal=0, frame_cnt=0).
//    GROW: each tick frame_cnt++; at frame_cnt==STEP_FRAMES-1 clear it and reveal++.
//    GROW --reveal reaches MAX_H--> HOLD, MAX_H = max_i(y_bot[i]-y_top[i]+1), 11-bit.
//    Ladders shorter than MAX_H saturate at their own top via max() above.
//    HOLD: grow_done=1. Any state --start_game=0--> IDLE, reveal=0 same cycle (no hit next line).
//  - start_game drop and tick in same cycle: IDLE wins, no increment.
//  - Position ports sampled every cycle; changes take effect on next pixel (no shadowing).
//  - All coordinate arithmetic 11-bit unsigned; x_left+TILE_W computed 12-bit, no wrap.
// STRUCTURE
//  - vgaPkg: add LADDER_MAX = 8 and typedef coord_t (logic [10:0]); reuse VER_PIXELS.
//  - Timing/background pipe: existing delay module (WIDTH 38, CLK_DEL 2) plus C3 register.
//  - One sub-module: ladder_grow_fsm (vsync edge detect, frame_cnt, reveal, grow_done).
//  - Hit/priority logic: generate loop + priority encoder in this module.
// TESTING
//  - rst_n=0 mid-frame with start_game=1 -> all out.* 0, grow_done 0 same cycle; GROW restarts at 0.
//  - NUM_LADDERS=1, x=480,y_top=239,y_bot=270, STEP_FRAMES=1, ROM=addr -> after 32 vsyncs
//    grow_done=1; pixel (hcount 485,vcount 250) gives addr {11,5}, out.rgb 3 clk later.
//  - Frame 5 of growth: only vcount 266..270 show ladder; vcount 265 passes background rgb.
//  - Ladders 0/1 overlap at x=500..511 -> ladder 0 texels shown; ROM=KEY_RGB -> background shown.
//  - hblnk=1 inside a ladder box -> out.rgb=12'h888; hcount=x_left+TILE_W -> no hit (exclusive edge).
//  - start_game 1->0 during GROW coincident with vsync -> FSM IDLE, reveal 0, no ladder next frame.

Source files
------------

// File: rtl/ladder_array_renderer_pkg.sv
// Shared types for the ladder overlay: screen coordinates, the 38-bit VGA bundle
// carried through the pipe, and the growth sequencer state encoding.
package ladder_array_renderer_pkg;

  localparam int LADDER_MAX = 8;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int VGA_BUS_W  = 38;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    GROW_IDLE = 2'd0,
    GROW_RUN  = 2'd1,
    GROW_HOLD = 2'd2
  } grow_state_e;

  typedef struct packed {
    coord_t      vcount;
    logic        vsync;
    logic        vblnk;
    coord_t      hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_bus_t;

  // Inclusive row span of a ladder box; callers guarantee bot >= top.
  function automatic coord_t ladder_height(input coord_t top, input coord_t bot);
    return bot - top + 11'd1;
  endfunction

endpackage

// File: rtl/ladder_array_renderer_if.sv
// VGA timing + rgb bundle passed between overlay stages. in/out are the sink/source
// views used by a stage; master/slave alias them for the stage driving the chain.
interface vga_if;
  import ladder_array_renderer_pkg::*;

  coord_t      vcount;
  logic        vsync;
  logic        vblnk;
  coord_t      hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in     (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out    (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/ladder_array_renderer_grow_fsm.sv
// Ladder growth sequencer: detects frame starts on vsync and raises the revealed
// height by one row every STEP_FRAMES frames until the tallest ladder is complete.
//  state     | meaning
//  GROW_IDLE | game not running, ladders hidden, reveal held at 0
//  GROW_RUN  | reveal advances one row per STEP_FRAMES frame ticks
//  GROW_HOLD | tallest ladder fully shown, grow_done high
module ladder_grow_fsm
  import ladder_array_renderer_pkg::*;
#(
  parameter int STEP_FRAMES = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start_game,
  input  logic   vsync,
  input  coord_t max_h,
  output coord_t reveal,
  output logic   grow_done,
  output logic   active
);

  localparam int              FC_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(STEP_FRAMES - 1);

  grow_state_e     state_d, state_q;
  coord_t          reveal_d, reveal_q;
  logic [FC_W-1:0] frame_cnt_d, frame_cnt_q;
  logic            vsync_prev_d, vsync_prev_q;
  logic            grow_done_d, grow_done_q;
  logic            active_d, active_q;
  logic            tick;

  assign tick = vsync & ~vsync_prev_q;

  always_comb begin
    state_d      = state_q;
    reveal_d     = reveal_q;
    frame_cnt_d  = frame_cnt_q;
    vsync_prev_d = vsync;
    // Dropping start_game overrides everything, including a coincident tick.
    if (!start_game) begin
      state_d     = GROW_IDLE;
      reveal_d    = '0;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        GROW_IDLE: begin
          state_d     = GROW_RUN;
          reveal_d    = '0;
          frame_cnt_d = '0;
        end
        GROW_RUN: begin
          if (reveal_q >= max_h) begin
            state_d = GROW_HOLD;
          end else if (tick) begin
            if (frame_cnt_q == FC_LAST) begin
              frame_cnt_d = '0;
              reveal_d    = reveal_q + 11'd1;
              if (reveal_d >= max_h) state_d = GROW_HOLD;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        GROW_HOLD: state_d = GROW_HOLD;
        default:   state_d = GROW_IDLE;
      endcase
    end
    grow_done_d = (state_d == GROW_HOLD);
    active_d    = (state_d != GROW_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= GROW_IDLE;
      reveal_q     <= '0;
      frame_cnt_q  <= '0;
      vsync_prev_q <= 1'b0;
      grow_done_q  <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      reveal_q     <= reveal_d;
      frame_cnt_q  <= frame_cnt_d;
      vsync_prev_q <= vsync_prev_d;
      grow_done_q  <= grow_done_d;
      active_q     <= active_d;
    end
  end

  assign reveal    = reveal_q;
  assign grow_done = grow_done_q;
  assign active    = active_q;

endmodule

// File: rtl/ladder_array_renderer.sv
// Ladder overlay stage: draws NUM_LADDERS tiled-sprite ladders over the incoming
// background, each growing upward from its bottom row once the game starts.
module ladder_array_renderer
  import ladder_array_renderer_pkg::*;
#(
  parameter int          NUM_LADDERS = 4,
  parameter int          TILE_W      = 32,
  parameter int          TILE_H      = 32,
  parameter int          STEP_FRAMES = 2,
  parameter logic [11:0] KEY_RGB     = 12'hF0F,
  parameter logic [11:0] BLANK_RGB   = 12'h888
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_game,
  input  logic [NUM_LADDERS*11-1:0]         x_left,
  input  logic [NUM_LADDERS*11-1:0]         y_top,
  input  logic [NUM_LADDERS*11-1:0]         y_bot,
  input  logic [11:0]                       rgb_pixel,
  output logic [$clog2(TILE_W*TILE_H)-1:0]  pixel_addr,
  output logic                              grow_done,
  vga_if.in                                 in,
  vga_if.out                                out
);

  localparam int COL_W  = $clog2(TILE_W);
  localparam int ROW_W  = $clog2(TILE_H);
  localparam int ADDR_W = ROW_W + COL_W;

  coord_t                 reveal;
  coord_t                 max_h;
  logic                   active;
  logic [NUM_LADDERS-1:0] hit_vec;
  logic [COL_W-1:0]       col_vec [NUM_LADDERS];
  logic [ROW_W-1:0]       row_vec [NUM_LADDERS];

  vga_bus_t          bus_in;
  vga_bus_t          bus1_d, bus1_q, bus2_d, bus2_q, out_d, out_q;
  logic              hit1_d, hit1_q, hit2_d, hit2_q;
  logic [ADDR_W-1:0] addr_d, addr_q;

  always_comb begin
    max_h = '0;
    for (int i = 0; i < NUM_LADDERS; i++) begin
      if (ladder_height(y_top[i*11 +: 11], y_bot[i*11 +: 11]) > max_h)
        max_h = ladder_height(y_top[i*11 +: 11], y_bot[i*11 +: 11]);
    end
  end

  ladder_grow_fsm #(
    .STEP_FRAMES (STEP_FRAMES)
  ) u_grow (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_game (start_game),
    .vsync      (in.vsync),
    .max_h      (max_h),
    .reveal     (reveal),
    .grow_done  (grow_done),
    .active     (active)
  );

  // Growth test is vcount + reveal > y_bot so a tall reveal never wraps below zero.
  for (genvar i = 0; i < NUM_LADDERS; i++) begin : g_ladder
    coord_t      xl, yt, yb;
    logic [11:0] x_end;
    logic        in_x, in_y;

    assign xl    = x_left[i*11 +: 11];
    assign yt    = y_top[i*11 +: 11];
    assign yb    = y_bot[i*11 +: 11];
    assign x_end = {1'b0, xl} + 12'(TILE_W);
    assign in_x  = (in.hcount >= xl) && ({1'b0, in.hcount} < x_end);
    assign in_y  = (in.vcount >= yt) && (in.vcount <= yb) &&
                   (({1'b0, in.vcount} + {1'b0, reveal}) > {1'b0, yb});

    assign hit_vec[i] = active && (reveal != '0) && in_x && in_y;
    assign col_vec[i] = COL_W'(in.hcount - xl);
    assign row_vec[i] = ROW_W'(in.vcount - yt);
  end

  assign bus_in = {in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk, in.rgb};

  always_comb begin
    addr_d = addr_q;
    for (int i = NUM_LADDERS - 1; i >= 0; i--) begin
      if (hit_vec[i]) addr_d = {row_vec[i], col_vec[i]};
    end
    hit1_d = |hit_vec;
    hit2_d = hit1_q;
    bus1_d = bus_in;
    bus2_d = bus1_q;
    // rgb_pixel now carries the texel addressed two cycles ago, aligned with bus2_q.
    out_d  = bus2_q;
    if (bus2_q.hblnk || bus2_q.vblnk)
      out_d.rgb = BLANK_RGB;
    else if (hit2_q && (rgb_pixel != KEY_RGB))
      out_d.rgb = rgb_pixel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      bus1_q <= '0;
      bus2_q <= '0;
      out_q  <= '0;
    end else begin
      addr_q <= addr_d;
      hit1_q <= hit1_d;
      hit2_q <= hit2_d;
      bus1_q <= bus1_d;
      bus2_q <= bus2_d;
      out_q  <= out_d;
    end
  end

  assign pixel_addr = addr_q;
  assign out.vcount = out_q.vcount;
  assign out.vsync  = out_q.vsync;
  assign out.vblnk  = out_q.vblnk;
  assign out.hcount = out_q.hcount;
  assign out.hsync  = out_q.hsync;
  assign out.hblnk  = out_q.hblnk;
  assign out.rgb    = out_q.rgb;

endmodule
